ex_mem_stage_reg: RTL and testbench

Parametrised, clocked EX/MEM pipeline register for the RISC-V core. It replaces the combinational EX/MEM latch and adds several features:
- valid/ready handshake with a one-entry skid buffer, so back-pressure from MEM does not combinationally reach EX;
- synchronous flush for branch or exception squash;
- bubble-gated memory and writeback controls;
- a forwarding tap and a saturating stall counter.

It sits between the ALU/branch-adder stage and the data-memory stage.

---
 rtl/riscv_pipe_pkg.sv | 23 ++
 rtl/pipe_skid_slot.sv | 33 +++
 rtl/ex_mem_stage_reg.sv | 127 ++++++++++++
 tb/tb_ex_mem_stage_reg.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pipe_pkg.sv
// Shared types and field indices for the RISC-V pipeline registers.
package riscv_pipe_pkg;

  localparam int DEF_XLEN    = 32;
  localparam int DEF_RADDR_W = 5;

  localparam int M_BRANCH    = 2;
  localparam int M_MEMREAD   = 1;
  localparam int M_MEMWRITE  = 0;
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  typedef struct packed {
    logic [1:0]               wb_ctl;
    logic [2:0]               m_ctl;
    logic [DEF_XLEN-1:0]      add_result;
    logic                     zero;
    logic [DEF_XLEN-1:0]      alu_result;
    logic [DEF_XLEN-1:0]      rs2_data;
    logic [DEF_RADDR_W-1:0]   rd;
  } ex_mem_payload_t;

endpackage

// File: rtl/pipe_skid_slot.sv
// One pipeline slot: a valid flag plus a payload that only changes on load.
// Clear beats load, so a squash always empties the slot.
module pipe_skid_slot #(
  parameter int PAYLOAD_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_i,
  input  logic                 clear_i,
  input  logic [PAYLOAD_W-1:0] d_i,
  output logic                 valid_o,
  output logic [PAYLOAD_W-1:0] data_o
);

  logic                 valid_q;
  logic [PAYLOAD_W-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= d_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/ex_mem_stage_reg.sv
// EX/MEM pipeline register: main slot M feeds MEM, skid slot S absorbs one
// extra entry so in_ready is a pure flop output.
module ex_mem_stage_reg
  import riscv_pipe_pkg::*;
#(
  parameter int XLEN        = DEF_XLEN,
  parameter int RADDR_W     = DEF_RADDR_W,
  parameter int WB_W        = 2,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WB_W-1:0]        in_wb_ctl,
  input  logic [2:0]             in_m_ctl,
  input  logic [XLEN-1:0]        in_add_result,
  input  logic                   in_zero,
  input  logic [XLEN-1:0]        in_alu_result,
  input  logic [XLEN-1:0]        in_rs2_data,
  input  logic [RADDR_W-1:0]     in_rd,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WB_W-1:0]        wb_ctl,
  output logic                   branch,
  output logic                   memread,
  output logic                   memwrite,
  output logic [XLEN-1:0]        add_result,
  output logic                   zero,
  output logic [XLEN-1:0]        alu_result,
  output logic [XLEN-1:0]        rs2_data,
  output logic [RADDR_W-1:0]     rd,
  output logic                   branch_taken,
  output logic                   fwd_en,
  output logic [RADDR_W-1:0]     fwd_rd,
  output logic [XLEN-1:0]        fwd_data,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam int PW = WB_W + 3 + XLEN + 1 + XLEN + XLEN + RADDR_W;

  logic          m_valid, s_valid;
  logic [PW-1:0] m_data, s_data, in_data, m_d;
  logic          accept, m_free, m_stall;
  logic          m_load, m_clear, s_load, s_clear;

  logic [WB_W-1:0]    m_wb;
  logic [2:0]         m_m;
  logic [XLEN-1:0]    m_add, m_alu, m_rs2;
  logic               m_zero;
  logic [RADDR_W-1:0] m_rd;

  assign in_data = {in_wb_ctl, in_m_ctl, in_add_result, in_zero,
                    in_alu_result, in_rs2_data, in_rd};

  assign in_ready = ~s_valid;
  assign accept   = in_valid & in_ready;
  assign m_free   = out_ready | ~m_valid;
  assign m_stall  = m_valid & ~out_ready;

  // S always drains into M first to keep FIFO order.
  assign m_d     = s_valid ? s_data : in_data;
  assign m_load  = ~flush & m_free & (s_valid | accept);
  assign m_clear = flush | (m_free & ~s_valid & ~accept);
  assign s_load  = ~flush & ~m_free & accept;
  assign s_clear = flush | (m_free & s_valid);

  pipe_skid_slot #(.PAYLOAD_W(PW)) u_main (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (m_load),
    .clear_i (m_clear),
    .d_i     (m_d),
    .valid_o (m_valid),
    .data_o  (m_data)
  );

  pipe_skid_slot #(.PAYLOAD_W(PW)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (s_load),
    .clear_i (s_clear),
    .d_i     (in_data),
    .valid_o (s_valid),
    .data_o  (s_data)
  );

  assign {m_wb, m_m, m_add, m_zero, m_alu, m_rs2, m_rd} = m_data;

  // Bubbles must never touch memory, redirect the PC or write a register.
  always_comb begin
    wb_ctl              = m_wb;
    wb_ctl[WB_REGWRITE] = m_wb[WB_REGWRITE] & m_valid;
  end

  assign out_valid    = m_valid;
  assign branch       = m_m[M_BRANCH];
  assign memread      = m_m[M_MEMREAD] & m_valid;
  assign memwrite     = m_m[M_MEMWRITE] & m_valid;
  assign add_result   = m_add;
  assign zero         = m_zero;
  assign alu_result   = m_alu;
  assign rs2_data     = m_rs2;
  assign rd           = m_rd;
  assign branch_taken = m_valid & m_m[M_BRANCH] & m_zero;

  assign fwd_en   = m_valid & m_wb[WB_REGWRITE] & (m_rd != '0);
  assign fwd_rd   = m_rd;
  assign fwd_data = m_alu;

  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (m_stall && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Directed bench for ex_mem_stage_reg; a second instance with a 4-bit stall
// counter shares the stimulus to exercise saturation.
module tb_ex_mem_stage_reg;
  import riscv_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [1:0]  in_wb_ctl;
  logic [2:0]  in_m_ctl;
  logic [31:0] in_add_result, in_alu_result, in_rs2_data;
  logic        in_zero;
  logic [4:0]  in_rd;
  logic        out_ready;

  logic        in_ready, out_valid, branch, memread, memwrite, zero;
  logic        branch_taken, fwd_en;
  logic [1:0]  wb_ctl;
  logic [31:0] add_result, alu_result, rs2_data, fwd_data;
  logic [4:0]  rd, fwd_rd;
  logic [15:0] stall_cnt;

  logic        b_in_ready, b_out_valid, b_branch, b_memread, b_memwrite, b_zero;
  logic        b_branch_taken, b_fwd_en;
  logic [1:0]  b_wb_ctl;
  logic [31:0] b_add_result, b_alu_result, b_rs2_data, b_fwd_data;
  logic [4:0]  b_rd, b_fwd_rd;
  logic [3:0]  b_stall_cnt;

  int checks = 0;
  int failures = 0;
  int exp_stall = 0;

  always #5 clk = ~clk;

  ex_mem_stage_reg dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_wb_ctl(in_wb_ctl), .in_m_ctl(in_m_ctl), .in_add_result(in_add_result),
    .in_zero(in_zero), .in_alu_result(in_alu_result), .in_rs2_data(in_rs2_data),
    .in_rd(in_rd), .out_valid(out_valid), .out_ready(out_ready), .wb_ctl(wb_ctl),
    .branch(branch), .memread(memread), .memwrite(memwrite), .add_result(add_result),
    .zero(zero), .alu_result(alu_result), .rs2_data(rs2_data), .rd(rd),
    .branch_taken(branch_taken), .fwd_en(fwd_en), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .stall_cnt(stall_cnt)
  );

  ex_mem_stage_reg #(.STALL_CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_wb_ctl(in_wb_ctl), .in_m_ctl(in_m_ctl), .in_add_result(in_add_result),
    .in_zero(in_zero), .in_alu_result(in_alu_result), .in_rs2_data(in_rs2_data),
    .in_rd(in_rd), .out_valid(b_out_valid), .out_ready(out_ready), .wb_ctl(b_wb_ctl),
    .branch(b_branch), .memread(b_memread), .memwrite(b_memwrite),
    .add_result(b_add_result), .zero(b_zero), .alu_result(b_alu_result),
    .rs2_data(b_rs2_data), .rd(b_rd), .branch_taken(b_branch_taken), .fwd_en(b_fwd_en),
    .fwd_rd(b_fwd_rd), .fwd_data(b_fwd_data), .stall_cnt(b_stall_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] alu, input logic [4:0] r,
                       input logic [1:0] wb, input logic [2:0] m, input logic z);
    in_valid      = v;
    in_alu_result = alu;
    in_rd         = r;
    in_wb_ctl     = wb;
    in_m_ctl      = m;
    in_zero       = z;
    in_add_result = alu + 32'h1000;
    in_rs2_data   = ~alu;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(1'b1, $urandom, 5'($urandom), 2'b11, 3'b111, 1'b1);
    repeat (3) tick();
    rst_n = 1'b1;
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (alu_result !== 32'h0 || add_result !== 32'h0 || rs2_data !== 32'h0 || rd !== 5'd0)
      begin failures++; $display("FAIL reset_payload alu=%h add=%h rs2=%h rd=%0d exp=0", alu_result, add_result, rs2_data, rd); end
    checks++; if (branch_taken !== 1'b0 || fwd_en !== 1'b0 || memread !== 1'b0 || memwrite !== 1'b0)
      begin failures++; $display("FAIL reset_gated bt=%b fe=%b mr=%b mw=%b exp=0", branch_taken, fwd_en, memread, memwrite); end
    checks++; if (stall_cnt !== 16'd0 || b_stall_cnt !== 4'd0)
      begin failures++; $display("FAIL reset_stall_cnt got=%0d/%0d exp=0", stall_cnt, b_stall_cnt); end
  endtask

  task automatic test_streaming();
    logic [31:0] vals [3];
    vals[0] = 32'h10; vals[1] = 32'h20; vals[2] = 32'h30;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, vals[i], 5'd1, 2'b10, 3'b010, 1'b0);
      tick();
      checks++; if (out_valid !== 1'b1 || alu_result !== vals[i])
        begin failures++; $display("FAIL stream_%0d valid=%b alu=%h exp valid=1 alu=%h", i, out_valid, alu_result, vals[i]); end
      checks++; if (in_ready !== 1'b1)
        begin failures++; $display("FAIL stream_ready_%0d got=%b exp=1", i, in_ready); end
    end
    checks++; if (memread !== 1'b1) begin failures++; $display("FAIL stream_memread got=%b exp=1", memread); end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0 || memread !== 1'b0)
      begin failures++; $display("FAIL stream_drain valid=%b memread=%b exp=0", out_valid, memread); end
  endtask

  task automatic test_stall_skid();
    out_ready = 1'b0;
    drive(1'b1, 32'hAA, 5'd2, 2'b10, 3'b000, 1'b0);
    tick();
    drive(1'b1, 32'hBB, 5'd3, 2'b10, 3'b000, 1'b0);
    tick(); exp_stall++;
    checks++; if (alu_result !== 32'hAA || in_ready !== 1'b0)
      begin failures++; $display("FAIL skid_full alu=%h ready=%b exp alu=aa ready=0", alu_result, in_ready); end
    drive(1'b1, 32'hCC, 5'd4, 2'b10, 3'b000, 1'b0);
    tick(); exp_stall++;
    checks++; if (alu_result !== 32'hAA || in_ready !== 1'b0 || out_valid !== 1'b1)
      begin failures++; $display("FAIL skid_hold alu=%h ready=%b valid=%b exp aa/0/1", alu_result, in_ready, out_valid); end
    out_ready = 1'b1; in_valid = 1'b0;
    tick();
    checks++; if (alu_result !== 32'hBB || rd !== 5'd3 || in_ready !== 1'b1 || out_valid !== 1'b1)
      begin failures++; $display("FAIL skid_drain alu=%h rd=%0d ready=%b valid=%b exp bb/3/1/1", alu_result, rd, in_ready, out_valid); end
    checks++; if (stall_cnt !== 16'(exp_stall))
      begin failures++; $display("FAIL skid_stall_cnt got=%0d exp=%0d", stall_cnt, exp_stall); end
    tick();
    checks++; if (out_valid !== 1'b0)
      begin failures++; $display("FAIL skid_no_cc valid=%b alu=%h exp valid=0", out_valid, alu_result); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 32'h11, 5'd6, 2'b00, 3'b001, 1'b0);
    tick();
    drive(1'b1, 32'h22, 5'd7, 2'b00, 3'b001, 1'b0);
    tick(); exp_stall++;
    checks++; if (memwrite !== 1'b1 || in_ready !== 1'b0)
      begin failures++; $display("FAIL flush_pre memwrite=%b ready=%b exp 1/0", memwrite, in_ready); end
    flush = 1'b1; out_ready = 1'b1;
    drive(1'b1, 32'h33, 5'd8, 2'b10, 3'b001, 1'b0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || memwrite !== 1'b0 || in_ready !== 1'b1)
      begin failures++; $display("FAIL flush_both valid=%b memwrite=%b ready=%b exp 0/0/1", out_valid, memwrite, in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0)
      begin failures++; $display("FAIL flush_drained valid=%b exp=0", out_valid); end
    drive(1'b1, 32'h55, 5'd9, 2'b10, 3'b001, 1'b0);
    tick();
    flush = 1'b1;
    drive(1'b1, 32'h44, 5'd10, 2'b10, 3'b001, 1'b0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || alu_result !== 32'h55)
      begin failures++; $display("FAIL flush_drop valid=%b alu=%h exp 0/55", out_valid, alu_result); end
    tick();
    checks++; if (out_valid !== 1'b0)
      begin failures++; $display("FAIL flush_drop_late valid=%b exp=0", out_valid); end
    checks++; if (stall_cnt !== 16'(exp_stall))
      begin failures++; $display("FAIL flush_keeps_cnt got=%0d exp=%0d", stall_cnt, exp_stall); end
  endtask

  task automatic test_branch_fwd();
    out_ready = 1'b1;
    drive(1'b1, 32'h77, 5'd5, 2'b10, 3'b100, 1'b1);
    tick();
    checks++; if (branch_taken !== 1'b1 || fwd_en !== 1'b1 || fwd_rd !== 5'd5 || fwd_data !== 32'h77)
      begin failures++; $display("FAIL bf_taken bt=%b fe=%b rd=%0d data=%h exp 1/1/5/77", branch_taken, fwd_en, fwd_rd, fwd_data); end
    checks++; if (wb_ctl !== 2'b10 || memread !== 1'b0 || add_result !== 32'h1077)
      begin failures++; $display("FAIL bf_fields wb=%b mr=%b add=%h exp 10/0/1077", wb_ctl, memread, add_result); end
    drive(1'b1, 32'h78, 5'd0, 2'b10, 3'b100, 1'b1);
    tick();
    checks++; if (fwd_en !== 1'b0 || branch_taken !== 1'b1)
      begin failures++; $display("FAIL bf_x0 fe=%b bt=%b exp 0/1", fwd_en, branch_taken); end
    drive(1'b1, 32'h79, 5'd5, 2'b10, 3'b100, 1'b1);
    tick();
    checks++; if (fwd_en !== 1'b1)
      begin failures++; $display("FAIL bf_reload fe=%b exp=1", fwd_en); end
    flush = 1'b1; in_valid = 1'b0;
    tick();
    flush = 1'b0;
    checks++; if (branch_taken !== 1'b0 || fwd_en !== 1'b0 || wb_ctl !== 2'b00 || rd !== 5'd5)
      begin failures++; $display("FAIL bf_flushed bt=%b fe=%b wb=%b rd=%0d exp 0/0/00/5", branch_taken, fwd_en, wb_ctl, rd); end
  endtask

  task automatic test_saturation();
    out_ready = 1'b0;
    drive(1'b1, 32'h99, 5'd1, 2'b00, 3'b000, 1'b0);
    tick();
    in_valid = 1'b0;
    repeat (20) begin tick(); exp_stall++; end
    checks++; if (b_stall_cnt !== 4'd15)
      begin failures++; $display("FAIL sat_cnt got=%0d exp=15", b_stall_cnt); end
    checks++; if (stall_cnt !== 16'(exp_stall))
      begin failures++; $display("FAIL sat_wide_cnt got=%0d exp=%0d", stall_cnt, exp_stall); end
    repeat (3) begin tick(); exp_stall++; end
    checks++; if (b_stall_cnt !== 4'd15 || stall_cnt !== 16'(exp_stall))
      begin failures++; $display("FAIL sat_hold got=%0d/%0d exp=15/%0d", b_stall_cnt, stall_cnt, exp_stall); end
  endtask

  task automatic test_reset_mid_stall();
    in_valid = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1)
      begin failures++; $display("FAIL rst_mid_pre ready=%b valid=%b exp 0/1", in_ready, out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || stall_cnt !== 16'd0 || b_stall_cnt !== 4'd0)
      begin failures++; $display("FAIL rst_mid valid=%b ready=%b cnt=%0d/%0d exp 0/1/0/0", out_valid, in_ready, stall_cnt, b_stall_cnt); end
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin failures++; $display("FAIL rst_mid_after valid=%b ready=%b exp 0/1", out_valid, in_ready); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_stall_skid();
    test_flush();
    test_branch_fwd();
    test_saturation();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
